matrix_serializer: RTL and testbench
====================================

MATRIX_SERIALIZER -- requirements
Module: matrix_serializer

Interface
REQ-001 Parameter NUMBER_BITS, 37, width of each signed fixed-point matrix element.
REQ-002 Parameter SEND_HEADER, 1, when 1 a header byte precedes the matrix payload.
REQ-003 Parameter HEADER_BYTE, 8'h52 ("R"), header byte value.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to serialize matrix_in.
REQ-007 matrix_in  input  8*NUMBER_BITS  2x2 complex matrix; element k=(row*4+col*2+imag) at bits [k*NUMBER_BITS +: NUMBER_BITS].
REQ-008 transmit_available  input  1  UART transmitter idle and able to accept a byte.
REQ-009 transmit_byte  output  8  byte to transmit; valid when transmit_ready is high.
REQ-010 transmit_ready  output  1  one-cycle pulse handing transmit_byte to the UART transmitter.
REQ-011 busy  output  1  high from cycle after accepted start until done.
REQ-012 done  output  1  one-cycle pulse after the last byte is issued.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 States: IDLE, ISSUE, HOLDOFF.
REQ-015 IDLE: start=1 SHALL latch matrix_in into an internal snapshot, clear byte counter, set busy, go to ISSUE; later matrix_in changes SHALL not affect output.
REQ-016 start while busy SHALL be ignored.
REQ-017 ISSUE: when transmit_available=1, SHALL drive current byte on transmit_byte, pulse transmit_ready for one cycle, advance counter, go to HOLDOFF; else remain in ISSUE with transmit_ready=0.
REQ-018 HOLDOFF: one cycle, transmit_available ignored; then ISSUE if bytes remain, else IDLE with done=1 for one cycle and busy=0.
REQ-019 transmit_ready SHALL never be high in two consecutive cycles.
REQ-020 transmit_byte SHALL hold its last value between pulses.
REQ-021 Byte order: header (if SEND_HEADER), then elements k=0..7 (row-major; real before imag), each as 5 bytes LSB-first.
REQ-022 Element byte 4 SHALL be bits [NUMBER_BITS-1:32] zero-extended to 8 bits (no sign extension); this matches the receive-side matrix decoder.
REQ-023 Total bytes SHALL be 40+SEND_HEADER; byte counter width SHALL hold 41 without wrap.
REQ-024 Latency, transmit_available constantly high: start sampled at cycle 0; transmit_ready pulses at cycles 1,3,5,...,2N-1 (N = total bytes); done at cycle 2N.
REQ-025 transmit_available falling or rising in HOLDOFF SHALL have no effect; in ISSUE only its current-cycle value is used.
REQ-026 start coinciding with done's cycle (IDLE re-entered) SHALL be accepted.

Reset
REQ-027 reset=1 SHALL force state IDLE, transmit_byte=0, transmit_ready=0, busy=0, done=0, counter=0, snapshot=0.
REQ-028 Reset mid-transfer SHALL abort without done, without further transmit_ready pulses, and the next start SHALL restart from the header.
REQ-029 reset SHALL dominate start in the same cycle.

Verification
REQ-030 Reset held 3 cycles, then released -> all outputs 0, no transmit_ready for 10 idle cycles.
REQ-031 matrix_in element0=37'd24296004000, element6=-37'd24296004003, others 0; start; transmit_available=1 -> bytes 52, A0,99,27,A8,05, 00 x25, 5D,66,D8,57,1A, 00 x5; pulses at cycles 1..81 odd; done at 82.
REQ-032 Same matrix, transmitter emulated by 3-bit timer reloaded to 7 on each transmit_ready -> identical 41-byte sequence, each pulse only while transmit_available=1, no consecutive pulses.
REQ-033 start pulsed again at byte 10 and matrix_in changed after start -> ignored; sequence unchanged, exactly one done.
REQ-034 reset asserted after byte 20 -> transmit_ready stays 0, busy=0, no done; new start -> header 52 transmitted first, full 41 bytes.
REQ-035 SEND_HEADER=0, all elements 37'h1F_FFFF_FFFF -> 40 bytes, each element FF,FF,FF,FF,1F; done at cycle 80.

Source files
------------

// File: rtl/matrix_serializer.sv
// matrix_serializer: streams a latched 2x2 complex fixed-point matrix to a UART transmitter, 5 bytes LSB-first per element
module matrix_serializer #(
  parameter int NUMBER_BITS = 37,
  parameter bit SEND_HEADER = 1'b1,
  parameter logic [7:0] HEADER_BYTE = 8'h52
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [8*NUMBER_BITS-1:0] matrix_in,
  input  logic                     transmit_available,
  output logic [7:0]               transmit_byte,
  output logic                     transmit_ready,
  output logic                     busy,
  output logic                     done
);
  localparam logic [5:0] HDR = 6'(int'(SEND_HEADER));
  localparam logic [5:0] TOTAL = 6'd40 + HDR;
  typedef enum logic [1:0] {IDLE, ISSUE, HOLDOFF} state_t;
  state_t state, state_n;
  logic [8*NUMBER_BITS-1:0] snap, snap_n;
  logic [5:0] cnt, cnt_n, idx;
  logic [2:0] k, b;
  logic [NUMBER_BITS-1:0] elem;
  logic [39:0] ext;
  logic [7:0] cur, byte_n;
  logic ready_n, busy_n, done_n;
  assign idx = cnt - HDR;
  assign k = 3'(idx / 6'd5);
  assign b = 3'(idx % 6'd5);
  assign elem = NUMBER_BITS'(snap >> (k * NUMBER_BITS));
  // top byte carries only the leftover element bits, zero-filled to match the receiver
  assign ext = 40'(elem);
  assign cur = (SEND_HEADER && cnt == 6'd0) ? HEADER_BYTE : 8'(ext >> {b, 3'b000});
  always_comb begin
    state_n = state;
    snap_n = snap;
    cnt_n = cnt;
    byte_n = transmit_byte;
    ready_n = 1'b0;
    busy_n = busy;
    done_n = 1'b0;
    case (state)
      IDLE: if (start) begin
        snap_n = matrix_in;
        cnt_n = 6'd0;
        busy_n = 1'b1;
        state_n = ISSUE;
      end
      ISSUE: if (transmit_available) begin
        byte_n = cur;
        ready_n = 1'b1;
        cnt_n = cnt + 6'd1;
        state_n = HOLDOFF;
      end
      HOLDOFF: begin
        state_n = (cnt == TOTAL) ? IDLE : ISSUE;
        done_n = (cnt == TOTAL);
        busy_n = (cnt != TOTAL);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      snap <= '0;
      cnt <= '0;
      transmit_byte <= '0;
      transmit_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      snap <= snap_n;
      cnt <= cnt_n;
      transmit_byte <= byte_n;
      transmit_ready <= ready_n;
      busy <= busy_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_matrix_serializer.sv
// tb_matrix_serializer: self-checking bench comparing both header variants against a byte-queue reference model
module tb_matrix_serializer;
  localparam int NB = 37;
  localparam int MW = 8 * NB;
  typedef struct {bit which; int pos; logic [7:0] val;} vec_t;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, avail = 1'b0, sel = 1'b0;
  logic [MW-1:0] matrix_in = '0;
  logic [7:0] byte_a, byte_b, t_byte;
  logic ready_a, ready_b, busy_a, busy_b, done_a, done_b, t_ready, t_busy, t_done;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$], got[$], cap31[$], cap35[$];
  int dcnt, dcyc;
  vec_t tv[$];
  always #5 clk = ~clk;
  matrix_serializer #(.NUMBER_BITS(NB), .SEND_HEADER(1'b1), .HEADER_BYTE(8'h52)) dut (
    .clk(clk), .reset(reset), .start(start && !sel), .matrix_in(matrix_in),
    .transmit_available(avail), .transmit_byte(byte_a), .transmit_ready(ready_a),
    .busy(busy_a), .done(done_a));
  matrix_serializer #(.NUMBER_BITS(NB), .SEND_HEADER(1'b0), .HEADER_BYTE(8'h52)) dut_nh (
    .clk(clk), .reset(reset), .start(start && sel), .matrix_in(matrix_in),
    .transmit_available(avail), .transmit_byte(byte_b), .transmit_ready(ready_b),
    .busy(busy_b), .done(done_b));
  assign t_byte = sel ? byte_b : byte_a;
  assign t_ready = sel ? ready_b : ready_a;
  assign t_busy = sel ? busy_b : busy_a;
  assign t_done = sel ? done_b : done_a;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic build(input logic [MW-1:0] m, input bit hdr);
    logic [NB-1:0] e;
    longint unsigned v;
    exp_q.delete();
    if (hdr) exp_q.push_back(8'h52);
    for (int k = 0; k < 8; k++) begin
      e = NB'(m >> (k * NB));
      v = 64'(e);
      for (int i = 0; i < 5; i++) begin
        exp_q.push_back(8'(v % 256));
        v = v / 256;
      end
    end
  endtask
  task automatic idle_watch(input string tag, input int n);
    int np = 0;
    repeat (n) begin
      @(posedge clk); #1;
      np += int'(ready_a) + int'(ready_b) + int'(done_a) + int'(done_b) + int'(busy_a) + int'(busy_b);
    end
    check(tag, 64'(np), 64'd0);
  endtask
  // mode 0: always available, 1: 3-bit UART timer emulation, 2: random availability
  // ev 1: re-pulse start and change matrix at byte 10, ev 2: reset after byte 20
  task automatic xfer(input logic [MW-1:0] m, input int mode, input int ev, input string tag);
    int c = 0, tmr = 0, n;
    bit prev_av, prev_rdy = 0, fired = 0, consec = 0, avbad = 0, tbad = 0;
    logic busy_done = 1'bx;
    build(m, !sel);
    n = exp_q.size();
    got.delete();
    dcnt = 0;
    dcyc = -1;
    matrix_in = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy"}, 64'(t_busy), 64'd1);
    avail = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    prev_av = avail;
    while (dcnt == 0 && c < 1000) begin
      @(posedge clk); #1;
      c++;
      if (t_ready) begin
        got.push_back(t_byte);
        if (mode == 0 && c != 2 * got.size() - 1) tbad = 1;
        if (prev_rdy) consec = 1;
        if (!prev_av) avbad = 1;
      end
      if (t_done) begin
        dcnt++;
        dcyc = c;
        busy_done = t_busy;
      end
      prev_rdy = t_ready;
      if (ev == 1 && got.size() == 10 && !fired) begin
        fired = 1;
        start = 1'b1;
        matrix_in = ~m;
      end else start = 1'b0;
      if (ev == 2 && got.size() == 20) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check({tag, " rst out"}, 64'({t_byte, t_ready, t_busy, t_done}), 64'd0);
        idle_watch({tag, " rst idle"}, 10);
        return;
      end
      if (mode == 1) begin
        if (t_ready) tmr = 7;
        else if (tmr > 0) tmr--;
        avail = (tmr == 0);
      end else if (mode == 2) avail = 1'($urandom_range(0, 1));
      prev_av = avail;
    end
    check({tag, " nbytes"}, 64'(got.size()), 64'(n));
    for (int i = 0; i < n && i < got.size(); i++) check($sformatf("%s b%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    check({tag, " done"}, 64'(dcnt), 64'd1);
    check({tag, " busy@done"}, 64'(busy_done), 64'd0);
    check({tag, " consec"}, 64'(consec), 64'd0);
    check({tag, " avail"}, 64'(avbad), 64'd0);
    if (mode == 0) begin
      check({tag, " pulse cyc"}, 64'(tbad), 64'd0);
      check({tag, " done cyc"}, 64'(dcyc), 64'(2 * n));
    end
  endtask
  initial begin
    logic [MW-1:0] m31, m35, mr;
    logic [7:0] q[$];
    tv.push_back('{0, 0, 8'h52}); tv.push_back('{0, 1, 8'hA0}); tv.push_back('{0, 2, 8'h99});
    tv.push_back('{0, 3, 8'h27}); tv.push_back('{0, 4, 8'hA8}); tv.push_back('{0, 5, 8'h05});
    tv.push_back('{0, 6, 8'h00}); tv.push_back('{0, 30, 8'h00}); tv.push_back('{0, 31, 8'h5D});
    tv.push_back('{0, 32, 8'h66}); tv.push_back('{0, 33, 8'hD8}); tv.push_back('{0, 34, 8'h57});
    tv.push_back('{0, 35, 8'h1A}); tv.push_back('{0, 40, 8'h00}); tv.push_back('{1, 0, 8'hFF});
    tv.push_back('{1, 4, 8'h1F}); tv.push_back('{1, 38, 8'hFF}); tv.push_back('{1, 39, 8'h1F});
    m31 = '0;
    m31[0 +: NB] = 37'd24296004000;
    m31[6 * NB +: NB] = NB'(64'd0 - 64'd24296004003);
    m35 = {8{37'h1F_FFFF_FFFF}};
    repeat (3) @(posedge clk);
    #1;
    check("reset outs", 64'({byte_a, ready_a, busy_a, done_a, byte_b, ready_b, busy_b, done_b}), 64'd0);
    reset = 1'b0;
    idle_watch("idle after reset", 10);
    xfer(m31, 0, 0, "r31");
    cap31 = got;
    xfer(m31, 1, 0, "r32");
    xfer(m31, 0, 1, "r33");
    idle_watch("r33 idle", 6);
    xfer(m31, 0, 2, "r34");
    xfer(m31, 0, 0, "r34b");
    check("r34b header", 64'(got.size() > 0 ? got[0] : 8'hxx), 64'h52);
    repeat (4) begin
      for (int k = 0; k < 8; k++) mr[k * NB +: NB] = NB'({$urandom(), $urandom()});
      xfer(mr, 2, 0, "rand");
    end
    sel = 1'b1;
    xfer(m35, 0, 0, "r35");
    cap35 = got;
    for (int k = 0; k < 8; k++) mr[k * NB +: NB] = NB'({$urandom(), $urandom()});
    xfer(mr, 1, 0, "rand nh");
    for (int i = 0; i < tv.size(); i++) begin
      q = tv[i].which ? cap35 : cap31;
      check($sformatf("tbl%0d", i), 64'(tv[i].pos < q.size() ? q[tv[i].pos] : 8'hxx), 64'(tv[i].val));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
